// File: rtl/pio_stream_loader.sv
// Boots one pio instance from program/config ROMs, then streams sample ROM words round-robin
// into NUM_CH TX FIFOs. Define PIO_STREAM_LOOP_EN to wrap the sample ROM instead of stopping.
module pio_stream_loader #(
    parameter int unsigned PROG_LEN   = 32,
    parameter int unsigned CONF_LEN   = 5,
    parameter int unsigned SMP_AW     = 15,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned PACE       = 8,
    parameter int unsigned SWAP_BYTES = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              run,
    input  logic [3:0]        tx_full,
    output logic [4:0]        prog_addr,
    input  logic [15:0]       prog_data,
    output logic [4:0]        conf_addr,
    input  logic [35:0]       conf_data,
    output logic [SMP_AW-1:0] smp_addr,
    input  logic [31:0]       smp_data,
    output logic [3:0]        action,
    output logic [31:0]       din,
    output logic [4:0]        index,
    output logic [1:0]        mindex,
    output logic              loaded,
    output logic              done
);

    localparam int unsigned PcW = $clog2(PACE) + 1;
    localparam logic [4:0] ProgLast = 5'(PROG_LEN - 1);
    localparam logic [4:0] ConfLast = (CONF_LEN == 0) ? 5'd0 : 5'(CONF_LEN - 1);
    localparam logic [1:0] ChLast = 2'(NUM_CH - 1);
    localparam logic [PcW-1:0] PcLoad = PcW'(PACE - 1);
`ifndef PIO_STREAM_LOOP_EN
    localparam logic [SMP_AW-1:0] SmpLast = {SMP_AW{1'b1}};
`endif

    typedef enum logic [1:0] {StProg, StConf, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        prog_addr_q, prog_addr_d;
    logic [4:0]        conf_addr_q, conf_addr_d;
    logic [SMP_AW-1:0] smp_addr_q, smp_addr_d;
    logic              iss_done_q, iss_done_d;
    logic              rd_vld_q, rd_vld_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [3:0]        action_q, action_d;
    logic [31:0]       din_q, din_d;
    logic [4:0]        index_q, index_d;
    logic [1:0]        mindex_q, mindex_d;
    logic              loaded_q, loaded_d;
    logic              done_q, done_d;
    logic [1:0]        ch_q, ch_d;
    logic [PcW-1:0]    pc_q, pc_d;
    logic              smp_ok_q, smp_ok_d;

    function automatic logic [31:0] swap_bytes(input logic [31:0] s);
        if (SWAP_BYTES != 0) return {s[23:16], s[31:24], s[7:0], s[15:8]};
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        conf_addr_d = conf_addr_q;
        smp_addr_d  = smp_addr_q;
        iss_done_d  = iss_done_q;
        rd_vld_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        action_d    = 4'd0;
        din_d       = din_q;
        index_d     = index_q;
        mindex_d    = mindex_q;
        loaded_d    = loaded_q;
        done_d      = done_q;
        ch_d        = ch_q;
        pc_d        = (pc_q != '0) ? pc_q - PcW'(1) : pc_q;
        smp_ok_d    = 1'b1;

        unique case (state_q)
            StProg: begin
                // Address issue runs one stage ahead of the ROM read-data stage.
                if (!iss_done_q) begin
                    rd_vld_d  = 1'b1;
                    rd_addr_d = prog_addr_q;
                    if (prog_addr_q == ProgLast) iss_done_d = 1'b1;
                    else prog_addr_d = prog_addr_q + 5'd1;
                end
                if (rd_vld_q) begin
                    action_d = 4'd1;
                    din_d    = {16'h0000, prog_data};
                    index_d  = rd_addr_q;
                    mindex_d = 2'd0;
                end
                if (iss_done_q && !rd_vld_q) begin
                    state_d    = StConf;
                    iss_done_d = (CONF_LEN == 0);
                end
            end
            StConf: begin
                if (!iss_done_q) begin
                    rd_vld_d  = 1'b1;
                    rd_addr_d = conf_addr_q;
                    if (conf_addr_q == ConfLast) iss_done_d = 1'b1;
                    else conf_addr_d = conf_addr_q + 5'd1;
                end
                if (rd_vld_q) begin
                    action_d = conf_data[35:32];
                    din_d    = conf_data[31:0];
                    index_d  = rd_addr_q;
                    mindex_d = 2'd0;
                end
                if (iss_done_q && !rd_vld_q) begin
                    state_d  = StRun;
                    loaded_d = 1'b1;
                end
            end
            StRun: begin
                // smp_ok guards against pushing stale ROM data right after an address step.
                if (run && smp_ok_q && (pc_q == '0) && !tx_full[ch_q]) begin
                    action_d = 4'd4;
                    mindex_d = ch_q;
                    din_d    = swap_bytes(smp_data);
                    smp_ok_d = 1'b0;
                    pc_d     = PcLoad;
                    ch_d     = (ch_q == ChLast) ? 2'd0 : ch_q + 2'd1;
`ifdef PIO_STREAM_LOOP_EN
                    smp_addr_d = smp_addr_q + SMP_AW'(1);
`else
                    if (smp_addr_q == SmpLast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        smp_addr_d = smp_addr_q + SMP_AW'(1);
                    end
`endif
                end
            end
            StDone: begin
            end
            default: state_d = StProg;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StProg;
            prog_addr_q <= '0;
            conf_addr_q <= '0;
            smp_addr_q  <= '0;
            iss_done_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            action_q    <= '0;
            din_q       <= '0;
            index_q     <= '0;
            mindex_q    <= '0;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            ch_q        <= '0;
            pc_q        <= '0;
            smp_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            conf_addr_q <= conf_addr_d;
            smp_addr_q  <= smp_addr_d;
            iss_done_q  <= iss_done_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            action_q    <= action_d;
            din_q       <= din_d;
            index_q     <= index_d;
            mindex_q    <= mindex_d;
            loaded_q    <= loaded_d;
            done_q      <= done_d;
            ch_q        <= ch_d;
            pc_q        <= pc_d;
            smp_ok_q    <= smp_ok_d;
        end
    end

    assign prog_addr = prog_addr_q;
    assign conf_addr = conf_addr_q;
    assign smp_addr  = smp_addr_q;
    assign action    = action_q;
    assign din       = din_q;
    assign index     = index_q;
    assign mindex    = mindex_q;
    assign loaded    = loaded_q;
    assign done      = done_q;

endmodule
